// File: rtl/shift_unit_arbiter.sv
// Round-robin arbiter sharing one shifter between two issue pipes. Two registered
// stages (operands, result) feed a valid/ready result port with full backpressure.

module shifter (
  input  logic [31:0] a_i,
  input  logic [4:0]  shamt_i,
  input  logic [4:0]  op_i,
  output logic [31:0] res_o
);

  logic [4:0]  neg_shamt;
  logic [31:0] bit_mask;

  always_comb begin
    // 32 - shamt wraps to 0 for shamt == 0, which keeps rotates by zero exact.
    neg_shamt = 5'd0 - shamt_i;
    bit_mask  = 32'd1 << shamt_i;
    res_o     = '0;
    case (op_i)
      5'b00000: res_o = a_i << shamt_i;
      5'b00001: res_o = a_i >> shamt_i;
      5'b00010: res_o = (a_i << shamt_i) | (a_i >> neg_shamt);
      5'b00011: res_o = (a_i >> shamt_i) | (a_i << neg_shamt);
      5'b00101: res_o = $signed(a_i) >>> shamt_i;
      5'b01000: res_o = a_i & ~bit_mask;
      5'b01011: res_o = {31'd0, a_i[shamt_i]};
      5'b11000: res_o = a_i ^ bit_mask;
      5'b11010: res_o = a_i | bit_mask;
      default:  res_o = '0;
    endcase
  end

endmodule

module shift_unit_arbiter #(
  parameter int TAG_W = 6
) (
  input  logic             cpu_clock_i,
  input  logic             cpu_resetn_i,
  input  logic             flush_i,
  input  logic [1:0]       req_valid_i,
  output logic [1:0]       req_ready_o,
  input  logic [31:0]      req0_a_i,
  input  logic [31:0]      req0_b_i,
  input  logic [4:0]       req0_op_i,
  input  logic [TAG_W-1:0] req0_tag_i,
  input  logic [31:0]      req1_a_i,
  input  logic [31:0]      req1_b_i,
  input  logic [4:0]       req1_op_i,
  input  logic [TAG_W-1:0] req1_tag_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [31:0]      res_o,
  output logic [TAG_W-1:0] res_tag_o,
  output logic             res_src_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high; a valid producer holds its payload until that edge.

  logic             s1_valid_q, s1_valid_d;
  logic [31:0]      s1_a_q, s1_a_d;
  logic [4:0]       s1_shamt_q, s1_shamt_d;
  logic [4:0]       s1_op_q, s1_op_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
  logic             s1_src_q, s1_src_d;

  logic             s2_valid_q, s2_valid_d;
  logic [31:0]      s2_res_q, s2_res_d;
  logic [TAG_W-1:0] s2_tag_q, s2_tag_d;
  logic             s2_src_q, s2_src_d;

  logic             prio_q, prio_d;

  logic             s2_free, s1_free, s1_move;
  logic [1:0]       grant;
  logic             accept, acc_src;
  logic [31:0]      shift_res;

  // Only the shift amount / bit index of operand b reaches the shifter.
  logic             unused_b_hi;
  assign unused_b_hi = ^{req0_b_i[31:5], req1_b_i[31:5]};

  shifter u_shifter (
    .a_i     (s1_a_q),
    .shamt_i (s1_shamt_q),
    .op_i    (s1_op_q),
    .res_o   (shift_res)
  );

  always_comb begin
    s2_free     = !s2_valid_q | res_ready_i;
    s1_free     = !s1_valid_q | s2_free;
    s1_move     = s1_valid_q & s2_free;
    grant[0]    = req_valid_i[0] & (!prio_q | !req_valid_i[1]);
    grant[1]    = req_valid_i[1] & ( prio_q | !req_valid_i[0]);
    req_ready_o = grant & {2{s1_free & !flush_i & cpu_resetn_i}};
    accept      = |req_ready_o;
    acc_src     = req_ready_o[1];
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_shamt_d = s1_shamt_q;
    s1_op_d    = s1_op_q;
    s1_tag_d   = s1_tag_q;
    s1_src_d   = s1_src_q;
    s2_valid_d = s2_valid_q;
    s2_res_d   = s2_res_q;
    s2_tag_d   = s2_tag_q;
    s2_src_d   = s2_src_q;
    prio_d     = prio_q;

    if (accept) begin
      s1_src_d = acc_src;
      prio_d   = ~acc_src;
      if (acc_src) begin
        s1_a_d     = req1_a_i;
        s1_shamt_d = req1_b_i[4:0];
        s1_op_d    = req1_op_i;
        s1_tag_d   = req1_tag_i;
      end else begin
        s1_a_d     = req0_a_i;
        s1_shamt_d = req0_b_i[4:0];
        s1_op_d    = req0_op_i;
        s1_tag_d   = req0_tag_i;
      end
    end

    if (s1_move) begin
      s2_res_d = shift_res;
      s2_tag_d = s1_tag_q;
      s2_src_d = s1_src_q;
    end

    // Flush drops both stages; accept is already blocked through req_ready_o.
    if (flush_i) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else begin
      if (accept)       s1_valid_d = 1'b1;
      else if (s1_move) s1_valid_d = 1'b0;
      if (s1_move)                        s2_valid_d = 1'b1;
      else if (s2_valid_q & res_ready_i)  s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge cpu_clock_i) begin
    if (!cpu_resetn_i) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_res_q   <= '0;
      s2_tag_q   <= '0;
      s2_src_q   <= 1'b0;
      prio_q     <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s2_res_q   <= s2_res_d;
      s2_tag_q   <= s2_tag_d;
      s2_src_q   <= s2_src_d;
      prio_q     <= prio_d;
    end
  end

  always_ff @(posedge cpu_clock_i) begin
    s1_a_q     <= s1_a_d;
    s1_shamt_q <= s1_shamt_d;
    s1_op_q    <= s1_op_d;
    s1_tag_q   <= s1_tag_d;
    s1_src_q   <= s1_src_d;
  end

  assign res_valid_o = s2_valid_q;
  assign res_o       = s2_res_q;
  assign res_tag_o   = s2_tag_q;
  assign res_src_o   = s2_src_q;

endmodule

// File: tb/tb_shift_unit_arbiter.sv
// Directed and random scenarios for shift_unit_arbiter, checked against a
// queue-based reference of accepted operations and their arrival times.

module tb_shift_unit_arbiter;

  localparam int TAG_W = 6;

  localparam logic [4:0] OP_SLL  = 5'b00000;
  localparam logic [4:0] OP_SRL  = 5'b00001;
  localparam logic [4:0] OP_ROL  = 5'b00010;
  localparam logic [4:0] OP_ROR  = 5'b00011;
  localparam logic [4:0] OP_SRA  = 5'b00101;
  localparam logic [4:0] OP_BCLR = 5'b01000;
  localparam logic [4:0] OP_BEXT = 5'b01011;
  localparam logic [4:0] OP_BINV = 5'b11000;
  localparam logic [4:0] OP_BSET = 5'b11010;

  logic             cpu_clock_i = 1'b0;
  logic             cpu_resetn_i;
  logic             flush_i;
  logic [1:0]       req_valid_i;
  logic [1:0]       req_ready_o;
  logic [31:0]      req0_a_i, req0_b_i, req1_a_i, req1_b_i;
  logic [4:0]       req0_op_i, req1_op_i;
  logic [TAG_W-1:0] req0_tag_i, req1_tag_i;
  logic             res_valid_o;
  logic             res_ready_i;
  logic [31:0]      res_o;
  logic [TAG_W-1:0] res_tag_o;
  logic             res_src_o;

  shift_unit_arbiter #(.TAG_W(TAG_W)) dut (
    .cpu_clock_i  (cpu_clock_i),
    .cpu_resetn_i (cpu_resetn_i),
    .flush_i      (flush_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req0_a_i     (req0_a_i),
    .req0_b_i     (req0_b_i),
    .req0_op_i    (req0_op_i),
    .req0_tag_i   (req0_tag_i),
    .req1_a_i     (req1_a_i),
    .req1_b_i     (req1_b_i),
    .req1_op_i    (req1_op_i),
    .req1_tag_i   (req1_tag_i),
    .res_valid_o  (res_valid_o),
    .res_ready_i  (res_ready_i),
    .res_o        (res_o),
    .res_tag_o    (res_tag_o),
    .res_src_o    (res_src_o)
  );

  always #5 cpu_clock_i = ~cpu_clock_i;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0]      res;
    logic [TAG_W-1:0] tag;
    logic             src;
    logic             defd;
    int               acc;
  } exp_t;

  exp_t exp_q[$];
  logic prio_m = 1'b0;

  logic [4:0] ops_tbl [9] = '{OP_SLL, OP_SRL, OP_ROL, OP_ROR, OP_SRA,
                              OP_BCLR, OP_BEXT, OP_BINV, OP_BSET};

  function automatic logic [32:0] ref_shift(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    int          s;
    logic [31:0] r;
    logic [63:0] w;
    logic        d;
    s = int'(b[4:0]);
    d = 1'b1;
    r = a;
    case (op)
      OP_SLL:  r = a << s;
      OP_SRL:  r = a >> s;
      OP_ROL:  repeat (s) r = {r[30:0], r[31]};
      OP_ROR:  repeat (s) r = {r[0], r[31:1]};
      OP_SRA:  begin w = {{32{a[31]}}, a} >> s; r = w[31:0]; end
      OP_BCLR: r[s] = 1'b0;
      OP_BEXT: r = {31'd0, a[s]};
      OP_BINV: r[s] = ~a[s];
      OP_BSET: r[s] = 1'b1;
      default: d = 1'b0;
    endcase
    return {d, r};
  endfunction

  // Pipe holds at most two ops; a full pipe only takes a new one if the head leaves.
  function automatic logic [1:0] exp_ready();
    if (!cpu_resetn_i || flush_i) return 2'b00;
    if (!(exp_q.size() < 2 || res_ready_i)) return 2'b00;
    if (req_valid_i[prio_m]) return prio_m ? 2'b10 : 2'b01;
    if (req_valid_i[!prio_m]) return prio_m ? 2'b01 : 2'b10;
    return 2'b00;
  endfunction

  function automatic logic exp_valid();
    return (exp_q.size() > 0) && (cyc >= exp_q[0].acc + 2);
  endfunction

  task automatic tick();
    logic [1:0]  g;
    logic        pop;
    logic [32:0] r;
    exp_t        e;
    g   = exp_ready();
    pop = exp_valid() && res_ready_i;
    @(posedge cpu_clock_i);
    if (!cpu_resetn_i) begin
      exp_q.delete();
      prio_m = 1'b0;
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (flush_i) exp_q.delete();
      else if (g != 2'b00) begin
        e.src = g[1];
        if (g[1]) begin r = ref_shift(req1_op_i, req1_a_i, req1_b_i); e.tag = req1_tag_i; end
        else      begin r = ref_shift(req0_op_i, req0_a_i, req0_b_i); e.tag = req0_tag_i; end
        e.defd = r[32];
        e.res  = r[31:0];
        e.acc  = cyc;
        exp_q.push_back(e);
        prio_m = ~g[1];
      end
    end
    cyc++;
    @(negedge cpu_clock_i);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_req(input int r, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] op, input logic [TAG_W-1:0] tag);
    if (r == 0) begin req0_a_i = a; req0_b_i = b; req0_op_i = op; req0_tag_i = tag; end
    else        begin req1_a_i = a; req1_b_i = b; req1_op_i = op; req1_tag_i = tag; end
  endtask

  task automatic rand_req();
    for (int r = 0; r < 2; r++) begin
      logic [4:0] op;
      op = ($urandom_range(0, 9) == 0) ? 5'($urandom) : ops_tbl[$urandom_range(0, 8)];
      drive_req(r, $urandom, $urandom, op, TAG_W'($urandom));
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    cpu_resetn_i = 1'b0;
    req_valid_i  = 2'b11;
    res_ready_i  = 1'b1;
    repeat (3) tick();
    #1;
    checks++;
    if (req_ready_o !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b exp 00", req_ready_o); end
    checks++;
    if (res_valid_o !== 1'b0 || res_o !== 32'd0 || res_tag_o !== '0 || res_src_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b res=%h tag=%0d src=%b exp all zero",
               res_valid_o, res_o, res_tag_o, res_src_o);
    end
    cpu_resetn_i = 1'b1;
    req_valid_i  = 2'b00;
    tick();
  endtask

  task automatic test_single();
    drive_req(0, 32'h8000_0000, 32'd4, OP_SRA, 6'd5);
    req_valid_i = 2'b01;
    res_ready_i = 1'b1;
    #1;
    checks++;
    if (req_ready_o !== 2'b01) begin errors++; $display("FAIL single_accept: got %b exp 01", req_ready_o); end
    tick();
    req_valid_i = 2'b00;
    for (int k = 1; k <= 3; k++) begin
      #1;
      checks++;
      if (res_valid_o !== exp_valid()) begin errors++; $display("FAIL single_valid: got %b exp %b", res_valid_o, exp_valid()); end
      if (k == 1) begin
        checks++;
        if (res_valid_o !== 1'b0) begin errors++; $display("FAIL single_early: got %b exp 0", res_valid_o); end
      end
      if (k == 2) begin
        checks++;
        if (res_valid_o !== 1'b1 || res_o !== 32'hF800_0000 || res_tag_o !== 6'd5 || res_src_o !== 1'b0) begin
          errors++;
          $display("FAIL single_result: got v=%b res=%h tag=%0d src=%b exp v=1 res=f8000000 tag=5 src=0",
                   res_valid_o, res_o, res_tag_o, res_src_o);
        end
      end
      tick();
    end
  endtask

  task automatic test_alternate();
    cpu_resetn_i = 1'b0;
    req_valid_i  = 2'b00;
    tick();
    cpu_resetn_i = 1'b1;
    drive_req(0, 32'h8000_0001, 32'd1, OP_ROL, 6'd10);
    drive_req(1, 32'h0000_0080, 32'd7, OP_BEXT, 6'd20);
    req_valid_i = 2'b11;
    res_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++;
      if (req_ready_o !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
        errors++; $display("FAIL alt_grant: cycle %0d got %b", i, req_ready_o);
      end
      if (i >= 2) begin
        checks++;
        if (res_valid_o !== 1'b1 || res_o !== ((i % 2 == 0) ? 32'h3 : 32'h1) ||
            res_src_o !== ((i % 2 == 0) ? 1'b0 : 1'b1) || res_tag_o !== ((i % 2 == 0) ? 6'd10 : 6'd20)) begin
          errors++;
          $display("FAIL alt_result: cycle %0d got v=%b res=%h tag=%0d src=%b", i, res_valid_o, res_o, res_tag_o, res_src_o);
        end
      end
      tick();
    end
    req_valid_i = 2'b00;
    repeat (2) begin
      #1;
      checks++;
      if (res_valid_o !== exp_valid()) begin errors++; $display("FAIL alt_drain: got %b exp %b", res_valid_o, exp_valid()); end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int nacc = 0;
    int ndel = 0;
    res_ready_i = 1'b0;
    req_valid_i = 2'b11;
    for (int i = 0; i < 5; i++) begin
      rand_req();
      #1;
      checks++;
      if (req_ready_o !== exp_ready()) begin errors++; $display("FAIL bp_ready: got %b exp %b", req_ready_o, exp_ready()); end
      if (i >= 2) begin
        checks++;
        if (res_valid_o !== 1'b1 || res_tag_o !== exp_q[0].tag || res_src_o !== exp_q[0].src ||
            (exp_q[0].defd && res_o !== exp_q[0].res)) begin
          errors++;
          $display("FAIL bp_hold: got v=%b res=%h tag=%0d exp res=%h tag=%0d", res_valid_o, res_o, res_tag_o,
                   exp_q[0].res, exp_q[0].tag);
        end
      end
      if ((req_valid_i & req_ready_o) != 2'b00) nacc++;
      tick();
    end
    checks++;
    if (nacc > 2) begin errors++; $display("FAIL bp_accepts: got %0d exp at most 2", nacc); end
    res_ready_i = 1'b1;
    req_valid_i = 2'b00;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (res_valid_o !== exp_valid()) begin errors++; $display("FAIL bp_drain_valid: got %b exp %b", res_valid_o, exp_valid()); end
      if (exp_valid()) begin
        checks++;
        if (res_tag_o !== exp_q[0].tag || res_src_o !== exp_q[0].src || (exp_q[0].defd && res_o !== exp_q[0].res)) begin
          errors++;
          $display("FAIL bp_drain_data: got res=%h tag=%0d src=%b exp res=%h tag=%0d src=%b",
                   res_o, res_tag_o, res_src_o, exp_q[0].res, exp_q[0].tag, exp_q[0].src);
        end
      end
      if (res_valid_o === 1'b1) ndel++;
      tick();
    end
    checks++;
    if (ndel != nacc) begin errors++; $display("FAIL bp_count: delivered %0d exp %0d", ndel, nacc); end
  endtask

  task automatic test_flush();
    res_ready_i = 1'b0;
    req_valid_i = 2'b01;
    drive_req(0, 32'd1, 32'd1, OP_SLL, 6'd1);
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (req_ready_o !== 2'b01) begin errors++; $display("FAIL flush_fill: got %b exp 01", req_ready_o); end
      tick();
      drive_req(0, 32'd1, 32'd1, OP_SLL, 6'd2);
    end
    flush_i     = 1'b1;
    req_valid_i = 2'b10;
    drive_req(1, 32'd5, 32'd2, OP_SLL, 6'd9);
    res_ready_i = 1'b1;
    #1;
    checks++;
    if (req_ready_o !== 2'b00) begin errors++; $display("FAIL flush_accept: got %b exp 00", req_ready_o); end
    tick();
    flush_i     = 1'b0;
    req_valid_i = 2'b00;
    #1;
    checks++;
    if (res_valid_o !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b exp 0", res_valid_o); end
    tick();
    drive_req(1, 32'd0, 32'd31, OP_BSET, 6'd7);
    req_valid_i = 2'b10;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (res_valid_o === 1'b1 && (res_tag_o === 6'd1 || res_tag_o === 6'd2 || res_tag_o === 6'd9)) begin
        errors++; $display("FAIL flush_leak: got tag %0d exp none of 1,2,9", res_tag_o);
      end
      if (k == 2) begin
        checks++;
        if (res_valid_o !== 1'b1 || res_o !== 32'h8000_0000 || res_tag_o !== 6'd7 || res_src_o !== 1'b1) begin
          errors++;
          $display("FAIL flush_after: got v=%b res=%h tag=%0d src=%b exp v=1 res=80000000 tag=7 src=1",
                   res_valid_o, res_o, res_tag_o, res_src_o);
        end
      end
      tick();
      req_valid_i = 2'b00;
    end
  endtask

  task automatic test_reset_mid();
    res_ready_i = 1'b0;
    drive_req(0, 32'd3, 32'd0, OP_SLL, 6'd3);
    req_valid_i = 2'b01;
    tick();
    req_valid_i = 2'b00;
    tick();
    #1;
    checks++;
    if (res_valid_o !== 1'b1 || res_tag_o !== 6'd3) begin
      errors++; $display("FAIL rmid_setup: got v=%b tag=%0d exp v=1 tag=3", res_valid_o, res_tag_o);
    end
    cpu_resetn_i = 1'b0;
    tick();
    req_valid_i = 2'b11;
    #1;
    checks++;
    if (res_valid_o !== 1'b0 || req_ready_o !== 2'b00) begin
      errors++; $display("FAIL rmid_clear: got v=%b ready=%b exp v=0 ready=00", res_valid_o, req_ready_o);
    end
    cpu_resetn_i = 1'b1;
    drive_req(0, 32'd1, 32'd4, OP_SLL, 6'd11);
    drive_req(1, 32'd1, 32'd5, OP_SLL, 6'd12);
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (req_ready_o !== ((i == 0) ? 2'b01 : 2'b10)) begin
        errors++; $display("FAIL rmid_grant: step %0d got %b", i, req_ready_o);
      end
      tick();
    end
    req_valid_i = 2'b00;
    res_ready_i = 1'b1;
    repeat (3) begin
      #1;
      checks++;
      if (res_valid_o !== exp_valid() || (exp_valid() && res_tag_o !== exp_q[0].tag)) begin
        errors++; $display("FAIL rmid_drain: got v=%b tag=%0d exp v=%b", res_valid_o, res_tag_o, exp_valid());
      end
      tick();
    end
  endtask

  task automatic test_ops();
    logic [4:0]  op_c  [3] = '{OP_BCLR, OP_BINV, OP_SRL};
    logic [31:0] a_c   [3] = '{32'hFFFF_FFFF, 32'h0, 32'h8000_0000};
    logic [31:0] b_c   [3] = '{32'd0, 32'd16, 32'd31};
    logic [31:0] res_c [3] = '{32'hFFFF_FFFE, 32'h0001_0000, 32'h0000_0001};
    res_ready_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k < 3) begin
        drive_req(0, a_c[k], b_c[k], op_c[k], TAG_W'(k + 40));
        req_valid_i = 2'b01;
      end else begin
        req_valid_i = 2'b00;
      end
      #1;
      if (k >= 2) begin
        checks++;
        if (res_valid_o !== 1'b1 || res_o !== res_c[k-2] || res_tag_o !== TAG_W'(k + 38)) begin
          errors++;
          $display("FAIL ops_result: op %0d got v=%b res=%h tag=%0d exp res=%h tag=%0d",
                   k - 2, res_valid_o, res_o, res_tag_o, res_c[k-2], k + 38);
        end
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      cpu_resetn_i = ($urandom_range(0, 99) != 0);
      flush_i      = ($urandom_range(0, 99) < 3);
      req_valid_i  = 2'($urandom);
      res_ready_i  = ($urandom_range(0, 3) != 0);
      rand_req();
      #1;
      checks++;
      if (req_ready_o !== exp_ready()) begin errors++; $display("FAIL rand_ready: cycle %0d got %b exp %b", cyc, req_ready_o, exp_ready()); end
      checks++;
      if (res_valid_o !== exp_valid()) begin errors++; $display("FAIL rand_valid: cycle %0d got %b exp %b", cyc, res_valid_o, exp_valid()); end
      if (exp_valid()) begin
        checks++;
        if (res_tag_o !== exp_q[0].tag || res_src_o !== exp_q[0].src || (exp_q[0].defd && res_o !== exp_q[0].res)) begin
          errors++;
          $display("FAIL rand_data: cycle %0d got res=%h tag=%0d src=%b exp res=%h tag=%0d src=%b",
                   cyc, res_o, res_tag_o, res_src_o, exp_q[0].res, exp_q[0].tag, exp_q[0].src);
        end
      end
      tick();
    end
    cpu_resetn_i = 1'b1;
    flush_i      = 1'b0;
    req_valid_i  = 2'b00;
    res_ready_i  = 1'b1;
    repeat (4) begin
      #1;
      checks++;
      if (res_valid_o !== exp_valid()) begin errors++; $display("FAIL rand_drain: got %b exp %b", res_valid_o, exp_valid()); end
      tick();
    end
  endtask

  initial begin
    cpu_resetn_i = 1'b0;
    flush_i      = 1'b0;
    req_valid_i  = 2'b00;
    res_ready_i  = 1'b0;
    drive_req(0, 32'd0, 32'd0, OP_SLL, '0);
    drive_req(1, 32'd0, 32'd0, OP_SLL, '0);
    test_reset();
    test_single();
    test_alternate();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_ops();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
